// File: rtl/alu_result_checker_if.sv
// Stimulus and response bundle between the ALU test driver and the checker.
// The driver owns the vectors and results; the checker owns stim_ready.
interface alu_result_checker_if #(
  parameter int WIDTH = 32
);
  logic             stim_valid;
  logic             stim_ready;
  logic [WIDTH-1:0] stim_a;
  logic [WIDTH-1:0] stim_b;
  logic [2:0]       stim_sel;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output stim_valid, stim_a, stim_b, stim_sel,
    output rsp_valid, rsp_data,
    input  stim_ready
  );

  modport slave (
    input  stim_valid, stim_a, stim_b, stim_sel,
    input  rsp_valid, rsp_data,
    output stim_ready
  );
endinterface

// File: rtl/alu_result_checker.sv
// In-order ALU response checker with reference model and session FSM.
// Define ALU_CHK_FIRST_ERR_EN to add first-mismatch capture outputs.
module alu_result_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  alu_result_checker_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
`ifdef ALU_CHK_FIRST_ERR_EN
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act,
`endif
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W:0]   total;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             hit;
  logic             uf_next;
  logic [WIDTH-1:0] exp_head;
  logic [WIDTH-1:0] model;

  function automatic logic [WIDTH-1:0] alu_ref(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       sel
  );
    logic [WIDTH-1:0] y;
    unique case (sel)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a ^ b;
      3'b101:  y = ~a;
      3'b110:  y = a << b[4:0];
      default: y = a >> b[4:0];
    endcase
    return y;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign total = {1'b0, pass_count} + {1'b0, err_count};

  // Pushes stop once the whole session has been issued.
  assign bus.stim_ready = (state == S_RUN) && !full &&
                          (push_cnt != num_lat);

  assign push     = bus.stim_valid && bus.stim_ready;
  assign pop      = (state == S_RUN) && bus.rsp_valid && !empty;
  assign exp_head = mem[rd_ptr[AW-1:0]];
  assign hit      = (exp_head == bus.rsp_data);
  assign uf_next  = underflow || (bus.rsp_valid && empty);
  assign model    = alu_ref(bus.stim_a, bus.stim_b, bus.stim_sel);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= model;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      pass_count <= '0;
      err_count  <= '0;
      underflow  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      push_cnt   <= '0;
      num_lat    <= '0;
`ifdef ALU_CHK_FIRST_ERR_EN
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            pass_count <= '0;
            err_count  <= '0;
            underflow  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            push_cnt   <= '0;
            num_lat    <= num_vectors;
`ifdef ALU_CHK_FIRST_ERR_EN
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_act   <= '0;
`endif
          end
        end
        S_RUN: begin
          if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            push_cnt <= push_cnt + 1'b1;
          end
          if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            if (hit) begin
              if (pass_count != '1)
                pass_count <= pass_count + 1'b1;
            end else begin
              if (err_count != '1)
                err_count <= err_count + 1'b1;
`ifdef ALU_CHK_FIRST_ERR_EN
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= total[CNT_W-1:0];
                first_err_exp   <= exp_head;
                first_err_act   <= bus.rsp_data;
              end
`endif
            end
          end
          underflow <= uf_next;
          if (total == {1'b0, num_lat}) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !uf_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
